// File: rtl/lut_delay_meter_pkg.sv
// Shared definitions for the LUT delay meter: FSM state encodings and prescale ratio.
package lut_delay_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned PRESCALE_RATIO = 16;
  localparam int unsigned PRESCALE_W     = $clog2(PRESCALE_RATIO);

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic meta;
  logic sync;

  // o_rise is the third flop: it holds (sync & ~prev) for the current sync value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      meta   <= i_d;
      sync   <= meta;
      o_rise <= meta & ~sync;
    end
  end

  assign o_q = sync;

endmodule

// File: rtl/lut_delay_meter.sv
// Ring-oscillator delay meter: enables the ring, counts its edges over a gate window.
// Optional feature: LUT_DELAY_METER_PRESCALE_EN inserts a /16 divider clocked by the ring.
module lut_delay_meter
  import lut_delay_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 32'd4096,
  parameter int unsigned SETTLE_CYCLES = 32'd16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_ring,
  output logic             o_ring_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  localparam int unsigned GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GATE_W-1:0]   GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  logic ring_src;
  logic ring_rise;
  logic unused_ring_sync;

`ifdef LUT_DELAY_METER_PRESCALE_EN
  logic [PRESCALE_W-1:0] div_q;
  logic                  div_clr;

  // Divider runs in the ring domain and is held clear whenever the ring is off
  assign div_clr = i_rst | ~o_ring_en;

  always_ff @(posedge i_ring or posedge div_clr) begin
    if (div_clr) div_q <= '0;
    else         div_q <= div_q + PRESCALE_W'(1);
  end

  assign ring_src = div_q[PRESCALE_W-1];
`else
  assign ring_src = i_ring;
`endif

  sync_edge_det u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (ring_src),
    .o_q    (unused_ring_sync),
    .o_rise (ring_rise)
  );

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic                ovf_q, ovf_d;
  logic                ring_en_d;
  logic                done_d;

  // Next state, counters and next-cycle output values
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    gate_d    = gate_q;
    edge_d    = edge_q;
    ovf_d     = ovf_q;
    ring_en_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
          edge_d   = '0;
          ovf_d    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_MEASURE;
          gate_d  = GATE_LOAD;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_MEASURE: begin
        if (ring_rise) begin
          if (edge_q == CNT_MAX) ovf_d  = 1'b1;
          else                   edge_d = edge_q + CNT_W'(1);
        end
        if (gate_q == '0) state_d = ST_DONE;
        else              gate_d  = gate_q - GATE_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ring_en_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    done_d    = (state_d == ST_DONE);
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      gate_q    <= '0;
      edge_q    <= '0;
      ovf_q     <= 1'b0;
      o_ring_en <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_count   <= '0;
      o_ovf     <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      ovf_q     <= ovf_d;
      o_ring_en <= ring_en_d;
      o_busy    <= ring_en_d;
      o_done    <= done_d;
      if (done_d) begin
        o_count <= edge_d;
        o_ovf   <= ovf_d;
      end
    end
  end

endmodule
